// File: rtl/mux_pkg.sv
// Shared constants and state encoding for the 16:1 mux scan controller.
package mux_pkg;

  localparam int unsigned CH_N  = 16;
  localparam int unsigned SEL_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/dwell_cnt.sv
// Dwell counter: counts 0..limit while enabled, wrapping to 0 after limit.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : synchronous clear to 0 (takes priority over en)
//   en         : advance the count this cycle
//   limit      : terminal count (dwell - 1)
//   last       : combinational, high while enabled and count == limit
module dwell_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         last
);

  logic [W-1:0] cnt;

  assign last = en && (cnt == limit);

  // Count register; wraps on the terminal count so it never exceeds limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == limit) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller for an external 16:1 mux: steps the select through all
// 16 channels, holding each for D clocks, and reassembles the serial bits.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   start      : request one full scan (ignored while running)
//   abort      : cancel a running scan at the next edge
//   dwell      : clocks per channel, 0 treated as 1, latched at start
//   y          : serial data from the mux
//   e          : active-low mux enable
//   s          : mux select
//   word       : reassembled word, bit n sampled while s = n
//   busy       : high while scanning
//   done       : one-cycle pulse when word updates
module mux_scan_ctrl
  import mux_pkg::*;
#(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               y,
  output logic               e,
  output logic [SEL_W-1:0]   s,
  output logic [CH_N-1:0]    word,
  output logic               busy,
  output logic               done
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CH_N - 1);

  state_t             state_q, state_d;
  logic [DWELL_W-1:0] limit_q, limit_d;
  logic [CH_N-2:0]    cap_buf, cap_buf_d;
  logic [SEL_W-1:0]   s_d;
  logic [CH_N-1:0]    word_d;
  logic               e_d, busy_d, done_d;
  logic               cnt_clr, cnt_en, cnt_last;

  dwell_cnt #(
    .W (DWELL_W)
  ) u_dwell_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .limit (limit_q),
    .last  (cnt_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    limit_d   = limit_q;
    cap_buf_d = cap_buf;
    s_d       = s;
    word_d    = word;
    e_d       = e;
    busy_d    = busy;
    done_d    = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        e_d     = 1'b1;
        busy_d  = 1'b0;
        if (start && !abort) begin
          state_d = RUN;
          // Terminal count is D-1; dwell of 0 behaves as 1.
          limit_d = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
          s_d     = '0;
          e_d     = 1'b0;
          busy_d  = 1'b1;
        end
      end

      RUN: begin
        if (abort) begin
          // Abort beats a simultaneous final capture: no word update, no done.
          state_d = IDLE;
          e_d     = 1'b1;
          busy_d  = 1'b0;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
          if (cnt_last) begin
            if (s == LAST_CH) begin
              word_d  = {y, cap_buf};
              done_d  = 1'b1;
              e_d     = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              cap_buf_d[s] = y;
              s_d          = s + SEL_W'(1);
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      limit_q <= '0;
      cap_buf <= '0;
      s       <= '0;
      word    <= '0;
      e       <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      limit_q <= limit_d;
      cap_buf <= cap_buf_d;
      s       <= s_d;
      word    <= word_d;
      e       <= e_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: elapsed-time reference model,
// directed timing scenarios and a randomized phase.
module tb_mux_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [7:0]  dwell;
  logic        y;
  logic        e;
  logic [3:0]  s;
  logic [15:0] word;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  logic        cmp_en = 1'b0;
  logic        y_mux  = 1'b1;
  logic [15:0] pat    = 16'h0000;

  mux_scan_ctrl #(.DWELL_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .dwell (dwell),
    .y     (y),
    .e     (e),
    .s     (s),
    .word  (word),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mux stand-in: y follows pattern bit selected by s, or random data.
  always @(negedge clk) begin
    if (y_mux) y = pat[s];
    else       y = 1'($urandom);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: scan progress tracked as elapsed clocks since start.
  bit          m_busy;
  int          m_d;
  int          m_el;
  int          m_s;
  int          m_ch;
  logic [15:0] m_bits;
  logic [15:0] m_word;
  bit          m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_s = 0; m_el = 0; m_d = 1;
      m_bits = '0; m_word = '0; m_done = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (start && !abort) begin
          m_busy = 1;
          m_d    = (dwell == 0) ? 1 : int'(dwell);
          m_el   = 0;
          m_s    = 0;
        end
      end else if (abort) begin
        m_busy = 0;
      end else begin
        m_el++;
        if (m_el % m_d == 0) begin
          m_ch = m_el / m_d - 1;
          m_bits[m_ch] = y;
          if (m_ch == 15) begin
            m_word = m_bits;
            m_done = 1;
            m_busy = 0;
          end else begin
            m_s = m_ch + 1;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("e",    32'(e),    32'(!m_busy));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("s",    32'(s),    32'(m_s));
      chk("word", 32'(word), 32'(m_word));
      chk("done", 32'(done), 32'(m_done));
    end
  end

  // Run one scan from idle; returns clocks from start edge to done and e-low count.
  task automatic scan_dir(input int dw, input logic [15:0] p, output int lat, output int elow);
    bit seen;
    @(negedge clk);
    dwell = 8'(dw); pat = p; y_mux = 1'b1; start = 1'b1; abort = 1'b0;
    @(posedge clk);
    lat = -1; elow = 0; seen = 0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat = c; seen = 1;
      end else if (!e) begin
        elow++;
      end
    end
    if (!seen) chk("scan_timeout", 32'(lat), 32'(0));
  endtask

  task automatic wait_sel(input int n, input int budget);
    bit ok = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      if (busy && s == 4'(n)) ok = 1;
    end
    if (!ok) chk("wait_sel_timeout", 32'(s), 32'(n));
  endtask

  int lat, elow, ndone;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; dwell = 8'd1;
    repeat (3) @(negedge clk);
    // Reset values.
    chk("rst_e", 32'(e), 32'(1)); chk("rst_s", 32'(s), 32'(0));
    chk("rst_word", 32'(word), 32'(0)); chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    cmp_en = 1'b1;

    // Start presented as reset releases is taken at the first edge.
    rst_n = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("first_edge_busy", 32'(busy), 32'(1));
    start = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;

    scan_dir(1, 16'hA5C3, lat, elow);
    chk("d1_lat", 32'(lat), 32'(16)); chk("d1_word", 32'(word), 32'hA5C3);
    chk("d1_elow", 32'(elow), 32'(16));
    scan_dir(0, 16'h5A3C, lat, elow);
    chk("d0_lat", 32'(lat), 32'(16)); chk("d0_word", 32'(word), 32'h5A3C);
    scan_dir(4, 16'h0001, lat, elow);
    chk("d4_lat", 32'(lat), 32'(64)); chk("d4_word", 32'(word), 32'h0001);
    chk("d4_elow", 32'(elow), 32'(64));

    // Abort during channel 9.
    scan_dir(1, 16'h1234, lat, elow);
    chk("w1234", 32'(word), 32'h1234);
    @(negedge clk);
    dwell = 8'd3; pat = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_sel(9, 200);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab9_e", 32'(e), 32'(1)); chk("ab9_busy", 32'(busy), 32'(0));
    chk("ab9_done", 32'(done), 32'(0)); chk("ab9_word", 32'(word), 32'h1234);

    // Abort on the channel-15 capture edge.
    @(negedge clk);
    dwell = 8'd2; pat = 16'hBEEF; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (31) @(negedge clk);
    chk("ab15_s", 32'(s), 32'(15));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab15_done", 32'(done), 32'(0)); chk("ab15_word", 32'(word), 32'h1234);
    chk("ab15_busy", 32'(busy), 32'(0));

    // Dwell changed mid-scan with start held: D stays 2, restart in done cycle.
    @(negedge clk);
    dwell = 8'd2; pat = 16'hC0DE; start = 1'b1;
    @(posedge clk);
    ndone = 0; lat = -1;
    for (int c = 0; c <= 32; c++) begin
      @(negedge clk);
      if (c == 3) dwell = 8'd9;
      if (done) begin ndone++; lat = c; end
    end
    chk("hold_ndone", 32'(ndone), 32'(1)); chk("hold_lat", 32'(lat), 32'(32));
    chk("hold_word", 32'(word), 32'hC0DE);
    @(negedge clk);
    chk("hold_restart", 32'(busy), 32'(1));
    start = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;

    // Asynchronous reset during channel 7.
    dwell = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_sel(7, 200);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_e", 32'(e), 32'(1)); chk("arst_s", 32'(s), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0)); chk("arst_word", 32'(word), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("arst_nodone", 32'(ndone), 32'(0));

    // Randomized phase.
    y_mux = 1'b0;
    repeat (4000) begin
      @(negedge clk);
      dwell = 8'($urandom_range(0, 3));
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 39) == 0);
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (80) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL_W, default 8, giving the bit width of the dwell input.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request one full 16-channel scan.
REQ-005 SHALL have port abort, input, 1 bit: synchronous cancel of a scan in progress.
REQ-006 SHALL have port dwell, input, DWELL_W bits: cycles each select value is held, with 0 treated as 1.
REQ-007 SHALL have port y, input, 1 bit: serial data returned by the downstream 16:1 mux.
REQ-008 SHALL have port e, output, 1 bit: active-low mux enable (0 = mux passes data).
REQ-009 SHALL have port s, output, 4 bits: mux select.
REQ-010 SHALL have port word, output, 16 bits: the reassembled word, with bit n sampled while s = n.
REQ-011 SHALL have port busy, output, 1 bit: high while a scan is in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when word is updated.

Function
REQ-013 SHALL implement the states IDLE and RUN.
REQ-014 In IDLE, outputs SHALL be e=1, busy=0, and s holding its last value.
REQ-015 At the edge where state is IDLE and start=1 and abort=0, the block SHALL latch D = max(dwell,1), set s=0, e=0, busy=1, cnt=0, and enter RUN.
REQ-016 In RUN, if cnt == D-1 at an edge, the block SHALL capture y into buf[s] and set cnt=0; otherwise it SHALL set cnt=cnt+1.
REQ-017 At a capture edge with s<15, the block SHALL set s=s+1 and stay in RUN.
REQ-018 At a capture edge with s=15, the block SHALL set word={y, buf[14:0]}, done=1, e=1, busy=0, and enter IDLE.
REQ-019 done SHALL be registered and return to 0 at the following edge.
REQ-020 For a start accepted at edge k, channel n SHALL be sampled at edge k+(n+1)*D; word and done SHALL be visible after edge k+16*D.
REQ-021 The dwell input SHALL be ignored while busy=1, because D is latched at start.
REQ-022 start SHALL be ignored while in RUN; no queuing.
REQ-023 A new start SHALL be accepted in the cycle where done=1, since state is already IDLE.
REQ-024 abort=1 in RUN SHALL force IDLE at the next edge with e=1, busy=0, done=0, and word unchanged.
REQ-025 abort SHALL win over a simultaneous capture of channel 15, so that no done pulse occurs.
REQ-026 abort=1 together with start=1 in IDLE SHALL cause the block to stay in IDLE.
REQ-027 cnt SHALL be DWELL_W bits wide and SHALL never exceed D-1.
REQ-028 s SHALL never wrap during a scan.
REQ-029 word SHALL change only at the REQ-018 edge.

Reset
REQ-030 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, e=1, s=0, word=0, buf=0, cnt=0, busy=0, done=0.
REQ-031 Reset asserted mid-scan SHALL discard the partial scan, with no done pulse.
REQ-032 After rst_n deasserts, start SHALL be honoured at the first clk edge.

Structure
REQ-033 Shared package mux_pkg SHALL hold CH_N=16, SEL_W=4, and the state enumeration (IDLE, RUN).
REQ-034 The dwell counter SHALL be a sub-module dwell_cnt with ports clk, rst_n, clr, en, limit, and last.
REQ-035 The top level SHALL hold the FSM, select register, capture buffer, and output word.

Verification
REQ-036 Reset mid-scan: pulse rst_n low during channel 7 -> e=1, s=0, busy=0, word=0 immediately; no done pulse follows.
REQ-037 dwell=1, mux model with i=16'hA5C3, start at edge k -> done after edge k+16, word=16'hA5C3, e=0 for exactly 16 cycles.
REQ-038 dwell=0 -> identical timing to dwell=1; dwell=4 with i=16'h0001 -> done after edge k+64, word=16'h0001.
REQ-039 abort during channel 9 with word previously 16'h1234 -> IDLE next edge, e=1, no done, word=16'h1234.
REQ-040 Change dwell from 2 to 9 mid-scan and hold start high throughout -> timing stays at D=2, exactly one scan completes, and a second scan starts in the done cycle.
REQ-041 abort asserted on the channel-15 capture edge -> no done, word unchanged.
